decode_ctrl_pipe: RTL
=====================

# decode_ctrl_pipe

Parametrised decode-and-control stage: turns the 32-bit instruction in ID into a registered ID/EX control bundle with sign-extended immediate. Adds load-use hazard detection with a configurable stall length, branch flush, illegal-instruction reporting and an extended ALU operation set (XOR, SLL, SRL, BNE). Sits between the IF/ID register and the EX stage. It is the single source of ID/EX control and of the stall request to PC and IF/ID.

## Interface
- XLEN, 64, datapath and immediate width (32 or 64)
- LOAD_LAT, 1, total stall cycles inserted per load-use hazard (1..4)
- EN_BNE, 1, 1 = decode BNE; 0 = BNE is illegal
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_i  in  32  instruction from IF/ID
- instr_valid_i  in  1  instr_i holds a real instruction
- flush_i  in  1  branch taken in EX; squash the ID instruction
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid_o  out  1  ID/EX holds a real instruction
- ex_alu_control_o  out  4  ALU op code (package enum)
- ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_alu_src_o, ex_branch_o, ex_branch_ne_o  out  1 each  ID/EX control
- ex_rd_o, ex_rs1_o, ex_rs2_o  out  5 each  register indices
- ex_imm_o  out  XLEN  sign-extended immediate
- illegal_o  out  1  one-cycle pulse, registered with the squashed slot

## Operation
- Decode is combinational; all outputs except stall_o come from the ID/EX register.
- Legal encodings, given as opcode/funct3/funct7:
  - LD: 0000011/011.
  - ADDI: 0010011/000.
  - SD: 0100011/011.
  - R-type 0110011: ADD 000/0000000, SUB 000/0100000, AND 111/0000000, OR 110/0000000, XOR 100/0000000, SLL 001/0000000, SRL 101/0000000.
  - BEQ: 1100011/000. BNE: 1100011/001, legal only when EN_BNE=1.
  - Everything else is illegal.
- Control values:
  - LD, ADDI, SD: ALU ADD, alu_src=1.
  - R-type: alu_src=0.
  - BEQ, BNE: ALU SUB, branch=1; branch_ne=1 for BNE only.
  - LD: mem_read=1 and mem_to_reg=1. SD: mem_write=1.
  - reg_write=1 for LD, ADDI and R-type, forced to 0 when rd=x0.
- Immediates: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}. All are sign-extended to XLEN. R-type gives 0.
- Bubble: ex_valid_o=0, every control bit 0, ALU ADD, rd/rs1/rs2/imm all 0.
- Hazard condition, all of:
  - ID/EX holds a valid LD with ex_rd_o≠0;
  - instr_valid_i=1;
  - rs1 == ex_rd_o (any opcode except none), or rs2 == ex_rd_o (R, S, B types only).
- State machine (RUN, STALL) with a stall counter cnt of width $clog2(LOAD_LAT+1):
  - RUN with no hazard: ID/EX ← decoded instruction (a bubble if instr_valid_i=0).
  - RUN with hazard: stall_o=1 and ID/EX ← bubble. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
  - STALL: stall_o=1, ID/EX ← bubble, cnt decrements. When cnt==1, the next state is RUN.
  - In RUN, the held instruction is re-evaluated; the bubble has cleared the hazard.
- Illegal instruction (valid, not flushed): ID/EX ← bubble and illegal_o=1 for that slot. No stall is raised.
- flush_i has priority over everything:
  - ID/EX ← bubble, stall_o=0, next state RUN, cnt ← 0;
  - illegal_o suppressed, hazard ignored.

## Timing
- Decode-to-EX latency: 1 cycle; instruction sampled at edge N appears on ex_* after edge N.
- Load-use with LOAD_LAT=L: exactly L bubbles, stall_o high for L consecutive cycles, then the consumer issues.
- Back-to-back LDs with no dependency: no stall.
- LD followed by a dependent LD: stalls as normal.
- flush_i during STALL: the stall aborts the same cycle and stall_o drops immediately (combinational).
- Reset (asynchronous, any cycle, including mid-STALL):
  - all ex_* outputs, illegal_o and cnt are 0; state RUN;
  - stall_o=0 while rst is high and in the first cycle after release.

## Structure
- Shared package decode_pkg holds:
  - opcode, funct3 and funct7 localparams;
  - alu_op_e (4-bit: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6);
  - a packed ctrl_t struct for the control bits;
  - the state enum {RUN, STALL}.
- Sub-module imm_gen (XLEN-parametrised, combinational) does immediate extraction and sign extension.
- Decode logic, hazard unit and FSM/counter live in decode_ctrl_pipe itself.

## Test plan
- Reset mid-STALL (LOAD_LAT=3, assert rst in the 2nd stall cycle) -> all outputs 0 and state RUN immediately; stall_o=0 after release.
- ADDI x5,x0,-1 (0xFFF00293), XLEN=64 -> next cycle ex_imm_o=0xFFFF_FFFF_FFFF_FFFF, reg_write=1, alu_src=1, ALU ADD.
- LD x6,8(x1) then ADD x7,x6,x2, with LOAD_LAT=1 and again with LOAD_LAT=3 -> stall_o high 1 and 3 cycles respectively, matching bubble count; ADD then reaches EX with ALU ADD and rd=7.
- LD x6 then SD x6,0(x2), with LOAD_LAT=2 -> 2 stall cycles (rs2 match); an LD to x0 followed by a use of x0 -> no stall.
- LOAD_LAT=3 stall, flush_i asserted in its 2nd cycle -> stall_o=0 that cycle, bubble next cycle, RUN; the following fresh instruction issues normally.
- BNE (funct3 001) with EN_BNE=0 -> bubble, illegal_o=1 for one cycle. With EN_BNE=1 -> branch=1, branch_ne=1, ALU SUB, B-immediate correct for offset -4.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings and types for the ID-stage decoder: opcode/funct fields,
// ALU operation codes, the ID/EX control bundle and the stall FSM states.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LD_SD = 3'b011;
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_XOR   = 3'b100;
  localparam logic [2:0] F3_SRL   = 3'b101;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_B    = 2'd3
  } imm_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    branch_ne;
    alu_op_e alu_op;
  } ctrl_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for I/S/B formats, sign-extended to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  imm_sel_e        imm_sel,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID stage: decodes the IF/ID instruction into the registered ID/EX control
// bundle, and owns load-use stalling, branch flush and illegal reporting.
module decode_ctrl_pipe
  import decode_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int LOAD_LAT = 1,
  parameter bit EN_BNE   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_i,
  input  logic            instr_valid_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            ex_valid_o,
  output logic [3:0]      ex_alu_control_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_mem_to_reg_o,
  output logic            ex_alu_src_o,
  output logic            ex_branch_o,
  output logic            ex_branch_ne_o,
  output logic [4:0]      ex_rd_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic            illegal_o
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  ctrl_t           dec_ctrl;
  logic            dec_legal;
  logic            dec_uses_rs2;
  imm_sel_e        imm_sel;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_ctrl     = '0;
    dec_legal    = 1'b0;
    dec_uses_rs2 = 1'b0;
    imm_sel      = IMM_NONE;
    case (opcode)
      OP_LOAD: begin
        dec_legal           = (funct3 == F3_LD_SD);
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        imm_sel             = IMM_I;
      end
      OP_IMM: begin
        dec_legal          = (funct3 == F3_ADDI);
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        imm_sel            = IMM_I;
      end
      OP_STORE: begin
        dec_legal          = (funct3 == F3_LD_SD);
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_uses_rs2       = 1'b1;
        imm_sel            = IMM_S;
      end
      OP_REG: begin
        dec_legal          = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_uses_rs2       = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: dec_ctrl.alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}: dec_ctrl.alu_op = ALU_SUB;
          {F7_BASE, F3_AND}: dec_ctrl.alu_op = ALU_AND;
          {F7_BASE, F3_OR }: dec_ctrl.alu_op = ALU_OR;
          {F7_BASE, F3_XOR}: dec_ctrl.alu_op = ALU_XOR;
          {F7_BASE, F3_SLL}: dec_ctrl.alu_op = ALU_SLL;
          {F7_BASE, F3_SRL}: dec_ctrl.alu_op = ALU_SRL;
          default:           dec_legal       = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        dec_legal          = (funct3 == F3_BEQ) || (EN_BNE && funct3 == F3_BNE);
        dec_ctrl.branch    = 1'b1;
        dec_ctrl.branch_ne = (funct3 == F3_BNE);
        dec_ctrl.alu_op    = ALU_SUB;
        dec_uses_rs2       = 1'b1;
        imm_sel            = IMM_B;
      end
      default: dec_legal = 1'b0;
    endcase
    if (rd == 5'd0) dec_ctrl.reg_write = 1'b0;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (instr_i),
    .imm_sel (imm_sel),
    .imm     (dec_imm)
  );

  // ID/EX register and FSM state
  logic            ex_valid_reg, ex_valid_next;
  ctrl_t           ex_ctrl_reg, ex_ctrl_next;
  logic [4:0]      ex_rd_reg, ex_rd_next;
  logic [4:0]      ex_rs1_reg, ex_rs1_next;
  logic [4:0]      ex_rs2_reg, ex_rs2_next;
  logic [XLEN-1:0] ex_imm_reg, ex_imm_next;
  logic            illegal_reg, illegal_next;
  state_e          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic            hazard;

  // Illegal instructions never stall: they are squashed into a bubble instead.
  assign hazard = ex_valid_reg && ex_ctrl_reg.mem_read && (ex_rd_reg != 5'd0) &&
                  instr_valid_i && dec_legal &&
                  ((rs1 == ex_rd_reg) || (dec_uses_rs2 && rs2 == ex_rd_reg));

  always_comb begin
    ex_valid_next = 1'b0;
    ex_ctrl_next  = '0;
    ex_rd_next    = '0;
    ex_rs1_next   = '0;
    ex_rs2_next   = '0;
    ex_imm_next   = '0;
    illegal_next  = 1'b0;
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    stall_o       = 1'b0;
    if (flush_i) begin
      state_next = ST_RUN;
      cnt_next   = '0;
    end else if (state_reg == ST_STALL) begin
      stall_o  = 1'b1;
      cnt_next = cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) state_next = ST_RUN;
    end else if (hazard) begin
      stall_o = 1'b1;
      if (LOAD_LAT > 1) begin
        state_next = ST_STALL;
        cnt_next   = CNT_W'(LOAD_LAT - 1);
      end
    end else if (instr_valid_i && !dec_legal) begin
      illegal_next = 1'b1;
    end else if (instr_valid_i) begin
      ex_valid_next = 1'b1;
      ex_ctrl_next  = dec_ctrl;
      ex_rd_next    = rd;
      ex_rs1_next   = rs1;
      ex_rs2_next   = rs2;
      ex_imm_next   = dec_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg <= 1'b0;
      ex_ctrl_reg  <= '0;
      ex_rd_reg    <= '0;
      ex_rs1_reg   <= '0;
      ex_rs2_reg   <= '0;
      ex_imm_reg   <= '0;
      illegal_reg  <= 1'b0;
      state_reg    <= ST_RUN;
      cnt_reg      <= '0;
    end else begin
      ex_valid_reg <= ex_valid_next;
      ex_ctrl_reg  <= ex_ctrl_next;
      ex_rd_reg    <= ex_rd_next;
      ex_rs1_reg   <= ex_rs1_next;
      ex_rs2_reg   <= ex_rs2_next;
      ex_imm_reg   <= ex_imm_next;
      illegal_reg  <= illegal_next;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign ex_valid_o       = ex_valid_reg;
  assign ex_alu_control_o = ex_ctrl_reg.alu_op;
  assign ex_reg_write_o   = ex_ctrl_reg.reg_write;
  assign ex_mem_read_o    = ex_ctrl_reg.mem_read;
  assign ex_mem_write_o   = ex_ctrl_reg.mem_write;
  assign ex_mem_to_reg_o  = ex_ctrl_reg.mem_to_reg;
  assign ex_alu_src_o     = ex_ctrl_reg.alu_src;
  assign ex_branch_o      = ex_ctrl_reg.branch;
  assign ex_branch_ne_o   = ex_ctrl_reg.branch_ne;
  assign ex_rd_o          = ex_rd_reg;
  assign ex_rs1_o         = ex_rs1_reg;
  assign ex_rs2_o         = ex_rs2_reg;
  assign ex_imm_o         = ex_imm_reg;
  assign illegal_o        = illegal_reg;

endmodule
